ring_seq_checker: RTL and testbench

Receive-side checker for the 4-bit rotating ring-counter pattern. It samples the counter output, learns the circulating pattern, locks once it sees consecutive correct rotations, and reports the binary position within the ring. Loss of rotation raises an error pulse and increments an error counter. It sits downstream of the ring counter as its decoder and integrity monitor.

---
 rtl/ring_seq_checker_if.sv | 36 +++
 rtl/ring_seq_checker.sv | 131 +++++++++++++
 tb/tb_ring_seq_checker.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ring_seq_checker_if.sv
// Sample/status bundle between a ring-counter source and its checker.
// The source side drives the sample and enable; the checker side drives the status.
interface ring_seq_checker_if #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
);
    localparam int POS_W = $clog2(WIDTH);

    logic                 en;
    logic [WIDTH-1:0]     ring_in;
    logic                 locked;
    logic [POS_W-1:0]     pos;
    logic [WIDTH-1:0]     seed;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output en,
        output ring_in,
        input  locked,
        input  pos,
        input  seed,
        input  err,
        input  err_count
    );

    modport slave (
        input  en,
        input  ring_in,
        output locked,
        output pos,
        output seed,
        output err,
        output err_count
    );
endinterface

// File: rtl/ring_seq_checker.sv
// Decoder and integrity monitor for a rotating ring counter: learns the pattern,
// locks after LOCK_CNT good rotations, reports ring position and counts rotation errors.
//
// state    | meaning
// ---------+------------------------------------------------------------------
// S_HUNT   | learning the pattern; counting consecutive good rotations
// S_LOCKED | pattern tracked; pos advances each sample, mismatch drops to HUNT
module ring_seq_checker #(
    parameter int WIDTH     = 4,
    parameter int LOCK_CNT  = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    ring_seq_checker_if.slave chk_if
);
    localparam int POS_W = $clog2(WIDTH);
    localparam int GC_W  = $clog2(LOCK_CNT + 1);
    localparam logic [GC_W-1:0]  LOCK_VAL = GC_W'(LOCK_CNT);
    localparam logic [POS_W-1:0] POS_MAX  = POS_W'(WIDTH - 1);

    typedef enum logic {
        S_HUNT,
        S_LOCKED
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     prev_q, prev_d;
    logic                 prev_valid_q, prev_valid_d;
    logic [GC_W-1:0]      good_cnt_q, good_cnt_d;
    logic                 locked_q, locked_d;
    logic [POS_W-1:0]     pos_q, pos_d;
    logic [WIDTH-1:0]     seed_q, seed_d;
    logic                 err_q, err_d;
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    logic [WIDTH-1:0]     expect_next;
    logic                 rot_match;
    logic                 degenerate;
    logic [GC_W-1:0]      good_inc;

    function automatic logic [WIDTH-1:0] rot(input logic [WIDTH-1:0] x);
        return {x[WIDTH-2:0], x[WIDTH-1]};
    endfunction

    assign expect_next = rot(prev_q);
    assign rot_match   = (chk_if.ring_in == expect_next);
    // Patterns invariant under rotation (all-0, all-1) carry no phase information.
    assign degenerate  = (rot(chk_if.ring_in) == chk_if.ring_in);
    assign good_inc    = good_cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_HUNT;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            good_cnt_q   <= '0;
            locked_q     <= 1'b0;
            pos_q        <= '0;
            seed_q       <= '0;
            err_q        <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            good_cnt_q   <= good_cnt_d;
            locked_q     <= locked_d;
            pos_q        <= pos_d;
            seed_q       <= seed_d;
            err_q        <= err_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        good_cnt_d   = good_cnt_q;
        locked_d     = locked_q;
        pos_d        = pos_q;
        seed_d       = seed_q;
        err_d        = 1'b0;
        err_cnt_d    = err_cnt_q;

        if (chk_if.en) begin
            unique case (state_q)
                S_HUNT: begin
                    prev_d       = chk_if.ring_in;
                    prev_valid_d = 1'b1;
                    if (prev_valid_q && rot_match && !degenerate) begin
                        if (good_inc == LOCK_VAL) begin
                            state_d    = S_LOCKED;
                            locked_d   = 1'b1;
                            seed_d     = chk_if.ring_in;
                            pos_d      = '0;
                            good_cnt_d = '0;
                        end else begin
                            good_cnt_d = good_inc;
                        end
                    end else begin
                        good_cnt_d = '0;
                    end
                end
                S_LOCKED: begin
                    if (rot_match) begin
                        prev_d = chk_if.ring_in;
                        pos_d  = (pos_q == POS_MAX) ? '0 : pos_q + 1'b1;
                    end else begin
                        // Re-seed from the offending sample so a shifted ring relocks quickly.
                        err_d        = 1'b1;
                        err_cnt_d    = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + 1'b1;
                        state_d      = S_HUNT;
                        locked_d     = 1'b0;
                        good_cnt_d   = '0;
                        prev_d       = chk_if.ring_in;
                        prev_valid_d = 1'b1;
                    end
                end
                default: state_d = S_HUNT;
            endcase
        end
    end

    assign chk_if.locked    = locked_q;
    assign chk_if.pos       = pos_q;
    assign chk_if.seed      = seed_q;
    assign chk_if.err       = err_q;
    assign chk_if.err_count = err_cnt_q;
endmodule

// File: tb/tb_ring_seq_checker.sv
// Bench for ring_seq_checker: two instances (8-bit and 2-bit error counter) share one
// directed stimulus stream and are compared every cycle against a behavioural model.
module tb_ring_seq_checker;
    localparam int W  = 4;
    localparam int LC = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ring_seq_checker_if #(.WIDTH(W), .ERR_CNT_W(8)) if_a ();
    ring_seq_checker_if #(.WIDTH(W), .ERR_CNT_W(2)) if_b ();

    ring_seq_checker #(.WIDTH(W), .LOCK_CNT(LC), .ERR_CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .chk_if(if_a.slave));
    ring_seq_checker #(.WIDTH(W), .LOCK_CNT(LC), .ERR_CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .chk_if(if_b.slave));

    logic         en_v   = 1'b0;
    logic [W-1:0] ring_v = '0;
    assign if_a.en      = en_v;
    assign if_a.ring_in = ring_v;
    assign if_b.en      = en_v;
    assign if_b.ring_in = ring_v;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int rot_i(input int x);
        return ((x << 1) | (x >> (W - 1))) & ((1 << W) - 1);
    endfunction

    bit m_locked, m_pv, m_err;
    int m_prev, m_good, m_pos, m_seed, m_ec8, m_ec2;

    always @(posedge clk) begin
        if (rst) begin
            m_locked = 0; m_pv = 0; m_err = 0;
            m_prev = 0; m_good = 0; m_pos = 0; m_seed = 0; m_ec8 = 0; m_ec2 = 0;
        end else begin
            m_err = 0;
            if (en_v) begin
                int r;
                r = int'(ring_v);
                if (!m_locked) begin
                    if (m_pv && r == rot_i(m_prev) && rot_i(r) != r) m_good++;
                    else m_good = 0;
                    m_prev = r;
                    m_pv   = 1;
                    if (m_good == LC) begin
                        m_locked = 1; m_seed = r; m_pos = 0; m_good = 0;
                    end
                end else if (r == rot_i(m_prev)) begin
                    m_prev = r;
                    m_pos  = (m_pos + 1) % W;
                end else begin
                    m_err  = 1;
                    m_ec8  = (m_ec8 < 255) ? m_ec8 + 1 : 255;
                    m_ec2  = (m_ec2 < 3) ? m_ec2 + 1 : 3;
                    m_locked = 0; m_good = 0; m_prev = r; m_pv = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a.locked",    32'(if_a.locked),    32'(m_locked));
            chk("a.pos",       32'(if_a.pos),       32'(m_pos));
            chk("a.seed",      32'(if_a.seed),      32'(m_seed));
            chk("a.err",       32'(if_a.err),       32'(m_err));
            chk("a.err_count", 32'(if_a.err_count), 32'(m_ec8));
            chk("b.locked",    32'(if_b.locked),    32'(m_locked));
            chk("b.pos",       32'(if_b.pos),       32'(m_pos));
            chk("b.err",       32'(if_b.err),       32'(m_err));
            chk("b.err_count", 32'(if_b.err_count), 32'(m_ec2));
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic [W-1:0] r, input logic e);
        @(negedge clk);
        ring_v = r;
        en_v   = e;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic lock_0001();
        step(4'b0001, 1'b1);
        step(4'b0010, 1'b1);
        step(4'b0100, 1'b1);
    endtask

    int pulses;
    int exp_ec2[5] = '{1, 2, 3, 3, 3};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("rst.locked",    32'(if_a.locked),    32'd0);
        chk("rst.err_count", 32'(if_a.err_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: lock and decode
        lock_0001();
        chk("t1.locked", 32'(if_a.locked), 32'd1);
        chk("t1.seed",   32'(if_a.seed),   32'h4);
        chk("t1.pos0",   32'(if_a.pos),    32'd0);
        step(4'b1000, 1'b1);
        chk("t1.pos1",   32'(if_a.pos),    32'd1);
        step(4'b0001, 1'b1);
        chk("t1.pos2",   32'(if_a.pos),    32'd2);
        chk("t1.err",    32'(if_a.err),    32'd0);

        // 2: corruption and relock
        step(4'b0011, 1'b1);
        chk("t2.err",    32'(if_a.err),       32'd1);
        chk("t2.ec",     32'(if_a.err_count), 32'd1);
        chk("t2.unlock", 32'(if_a.locked),    32'd0);
        step(4'b0110, 1'b1);
        chk("t2.errpulse", 32'(if_a.err),     32'd0);
        step(4'b1100, 1'b1);
        chk("t2.relock", 32'(if_a.locked),    32'd1);
        chk("t2.seed",   32'(if_a.seed),      32'hC);
        chk("t2.pos",    32'(if_a.pos),       32'd0);

        // 4: enable gating while locked at pos 1
        step(4'b1001, 1'b1);
        chk("t4.pos1", 32'(if_a.pos), 32'd1);
        step(4'b0000, 1'b0);
        step(4'b1111, 1'b0);
        step(4'b0101, 1'b0);
        step(4'b0111, 1'b0);
        step(4'b1010, 1'b0);
        chk("t4.hold_locked", 32'(if_a.locked),    32'd1);
        chk("t4.hold_pos",    32'(if_a.pos),       32'd1);
        chk("t4.hold_seed",   32'(if_a.seed),      32'hC);
        chk("t4.hold_ec",     32'(if_a.err_count), 32'd1);
        chk("t4.hold_err",    32'(if_a.err),       32'd0);
        step(4'b0011, 1'b1);
        chk("t4.pos2", 32'(if_a.pos), 32'd2);

        // 3: degenerate input from a fresh reset
        do_reset();
        repeat (20) step(4'b0000, 1'b1);
        repeat (20) step(4'b1111, 1'b1);
        chk("t3.locked", 32'(if_a.locked),    32'd0);
        chk("t3.ec",     32'(if_a.err_count), 32'd0);

        // 5: reset coincident with a mismatch, err_count at 3
        do_reset();
        lock_0001();
        repeat (3) begin
            step(4'b0000, 1'b1);
            lock_0001();
        end
        chk("t5.ec3",    32'(if_a.err_count), 32'd3);
        chk("t5.locked", 32'(if_a.locked),    32'd1);
        @(negedge clk);
        rst    = 1'b1;
        ring_v = 4'b1111;
        en_v   = 1'b1;
        @(posedge clk);
        #1;
        chk("t5.rst_err",    32'(if_a.err),       32'd0);
        chk("t5.rst_ec",     32'(if_a.err_count), 32'd0);
        chk("t5.rst_locked", 32'(if_a.locked),    32'd0);
        chk("t5.rst_pos",    32'(if_a.pos),       32'd0);
        chk("t5.rst_seed",   32'(if_a.seed),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        lock_0001();
        chk("t5.relock", 32'(if_a.locked), 32'd1);

        // 6: saturation of the 2-bit counter
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            step(4'b0000, 1'b1);
            if (if_b.err === 1'b1) pulses++;
            chk("t6.ec2", 32'(if_b.err_count), 32'(exp_ec2[k]));
            lock_0001();
        end
        chk("t6.pulses", 32'(pulses),          32'd5);
        chk("t6.ec8",    32'(if_a.err_count),  32'd5);

        // short-period seed 0101, pos wraps modulo WIDTH
        step(4'b0101, 1'b1);
        step(4'b1010, 1'b1);
        step(4'b0101, 1'b1);
        chk("sp.locked", 32'(if_a.locked), 32'd1);
        chk("sp.seed",   32'(if_a.seed),   32'h5);
        step(4'b1010, 1'b1);
        step(4'b0101, 1'b1);
        step(4'b1010, 1'b1);
        chk("sp.pos3", 32'(if_a.pos), 32'd3);
        step(4'b0101, 1'b1);
        chk("sp.wrap", 32'(if_a.pos), 32'd0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
